// File: rtl/round_share_arb_pkg.sv
// Rounding-mode constants, request/result payloads and the shared increment rule
// used by round_mult, round_share_arb and fp_mult.
package round_defs;

  localparam logic [2:0] IEEE_NEAR = 3'd0;
  localparam logic [2:0] IEEE_ZERO = 3'd1;
  localparam logic [2:0] IEEE_PINF = 3'd2;
  localparam logic [2:0] IEEE_NINF = 3'd3;
  localparam logic [2:0] NEAR_UP   = 3'd4;
  localparam logic [2:0] AWAY_ZERO = 3'd5;

  typedef struct packed {
    logic [24:0] mant;
    logic        guard;
    logic        sticky;
    logic        sign;
    logic [2:0]  round;
  } round_req_t;

  typedef struct packed {
    logic [24:0] mant;
    logic        inexact;
    logic        exp_inc;
    logic        src;
  } round_res_t;

  // Unknown modes fall into the default arm and round to nearest-even.
  function automatic logic round_incr(input round_req_t r);
    logic inx;
    inx = r.guard | r.sticky;
    case (r.round)
      IEEE_ZERO: round_incr = 1'b0;
      IEEE_PINF: round_incr = inx & ~r.sign;
      IEEE_NINF: round_incr = inx & r.sign;
      NEAR_UP:   round_incr = r.guard;
      AWAY_ZERO: round_incr = inx;
      default:   round_incr = r.guard & (r.sticky | r.mant[0]);
    endcase
  endfunction

endpackage

// File: rtl/round_share_arb_round_mult.sv
// Mantissa rounding: add the increment and renormalise when it carries into bit 24.
module round_mult
  import round_defs::*;
(
  input  round_req_t  req,
  output logic [24:0] mant
);

  logic [24:0] sum;

  always_comb begin
    sum  = req.mant + 25'(round_incr(req));
    mant = sum[24] ? {1'b0, sum[24:1]} : sum;
  end

endmodule

// File: rtl/round_share_arb.sv
// Two-lane round-robin front end sharing one round_mult through a two-stage
// valid/ready pipeline (S1 input register, S2 output register).
module round_share_arb
  import round_defs::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][24:0]      req_mant,
  input  logic [NREQ-1:0]            req_guard,
  input  logic [NREQ-1:0]            req_sticky,
  input  logic [NREQ-1:0]            req_sign,
  input  logic [NREQ-1:0][2:0]       req_round,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [24:0]                res_mant,
  output logic                       res_inexact,
  output logic                       res_exp_inc,
  output logic                       res_src,
  output logic [CNT_W-1:0]           inexact_cnt,
  output logic                       busy
);

  round_req_t [NREQ-1:0] lane_req;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_req[i] = '{mant: req_mant[i], guard: req_guard[i], sticky: req_sticky[i],
                           sign: req_sign[i], round: req_round[i]};
  end

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  round_req_t       s1_q, s1_d;
  logic             s1_src_q, s1_src_d;
  round_res_t       s2_q, s2_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv1, adv2, hs, exp_inc;
  logic [NREQ-1:0]  grant;
  logic [24:0]      rnd_mant;

  round_mult u_round (
    .req  (s1_q),
    .mant (rnd_mant)
  );

  always_comb begin
    adv2  = ~vld_pipe_q[2] | res_ready;
    adv1  = ~vld_pipe_q[1] | adv2;
    grant = '0;
    if (adv1) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    hs           = |(req_valid & grant);
    last_grant_d = hs ? grant[1] : last_grant_q;

    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s1_src_d   = s1_src_q;
    if (hs) begin
      vld_pipe_d[1] = 1'b1;
      s1_d          = lane_req[grant[1]];
      s1_src_d      = grant[1];
    end else if (adv2) begin
      vld_pipe_d[1] = 1'b0;
    end

    // Carry-out only happens when an all-ones mantissa is bumped.
    exp_inc = vld_pipe_q[1] & round_incr(s1_q) & (s1_q.mant[23:0] == 24'hFFFFFF);

    s2_d = s2_q;
    if (adv2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1])
        s2_d = '{mant: rnd_mant, inexact: s1_q.guard | s1_q.sticky,
                 exp_inc: exp_inc, src: s1_src_q};
    end

    cnt_d = cnt_q;
    if (vld_pipe_q[2] && res_ready && s2_q.inexact && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      s1_q         <= '0;
      s1_src_q     <= 1'b0;
      s2_q         <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      s1_q         <= s1_d;
      s1_src_q     <= s1_src_d;
      s2_q         <= s2_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready   = grant;
  assign res_valid   = vld_pipe_q[2];
  assign res_mant    = s2_q.mant;
  assign res_inexact = s2_q.inexact;
  assign res_exp_inc = s2_q.exp_inc;
  assign res_src     = s2_q.src;
  assign inexact_cnt = cnt_q;
  assign busy        = |vld_pipe_q;

endmodule

// File: tb/tb_round_share_arb.sv
// Scoreboard bench for round_share_arb: a negedge monitor pushes modelled results on
// each handshake and pops them on each delivered result; directed tests add constants.
module tb_round_share_arb;
  import round_defs::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready;
  logic [1:0][24:0] req_mant;
  logic [1:0]       req_guard, req_sticky, req_sign;
  logic [1:0][2:0]  req_round;
  logic             res_valid, res_ready;
  logic [24:0]      res_mant;
  logic             res_inexact, res_exp_inc, res_src;
  logic [15:0]      inexact_cnt;
  logic             busy;

  round_share_arb #(.NREQ(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mant(req_mant), .req_guard(req_guard), .req_sticky(req_sticky),
    .req_sign(req_sign), .req_round(req_round), .res_valid(res_valid),
    .res_ready(res_ready), .res_mant(res_mant), .res_inexact(res_inexact),
    .res_exp_inc(res_exp_inc), .res_src(res_src), .inexact_cnt(inexact_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0] sb[$];
  int          gnt_q[$];
  int          dlv_cyc[$];
  int          hs_cnt = 0;
  int          mcnt = 0;
  logic        hold_prev = 1'b0;
  logic [28:0] prev_res;
  logic [1:0]  last_rdy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Result packed as {src, exp_inc, inexact, mant}.
  function automatic logic [27:0] model(input logic [24:0] m, input logic g, input logic s,
                                        input logic sg, input logic [2:0] md, input logic src);
    logic        up;
    logic [25:0] sum;
    logic [24:0] r;
    case (md)
      IEEE_ZERO: up = 1'b0;
      IEEE_PINF: up = (g | s) & ~sg;
      IEEE_NINF: up = (g | s) & sg;
      NEAR_UP:   up = g;
      AWAY_ZERO: up = g | s;
      default:   up = g & (s | m[0]);
    endcase
    sum = {1'b0, m} + 26'(up);
    r   = sum[24] ? sum[25:1] : sum[24:0];
    return {src, sum[24], g | s, r};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        mcnt      = 0;
        hold_prev = 1'b0;
      end else begin
        chk("cnt", 32'(inexact_cnt), 32'(mcnt));
        chk("rdy_onehot", 32'(req_ready != 2'b11), 32'd1);
        chk("rdy_no_vld", 32'(req_ready & ~req_valid), 32'd0);
        if (hold_prev)
          chk("stable", 32'({res_src, res_exp_inc, res_inexact, res_mant}), 32'(prev_res[27:0]));
        hold_prev = res_valid & ~res_ready;
        prev_res  = {res_valid, res_src, res_exp_inc, res_inexact, res_mant};
        for (int i = 0; i < 2; i++)
          if (req_valid[i] && req_ready[i]) begin
            sb.push_back(model(req_mant[i], req_guard[i], req_sticky[i], req_sign[i],
                               req_round[i], i[0]));
            gnt_q.push_back(i);
            hs_cnt++;
          end
        if (res_valid && res_ready) begin
          dlv_cyc.push_back(cyc);
          if (sb.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
          else chk("res", 32'({res_src, res_exp_inc, res_inexact, res_mant}), 32'(sb.pop_front()));
          if (res_inexact && mcnt != 16'hFFFF) mcnt++;
        end
      end
    end
  end

  task automatic rand_lane(input int i);
    req_mant[i]   = {2'b01, 23'($urandom)};
    if ($urandom_range(0, 3) == 0) req_mant[i] = 25'h0FFFFFF;
    req_guard[i]  = 1'($urandom);
    req_sticky[i] = 1'($urandom);
    req_sign[i]   = 1'($urandom);
    req_round[i]  = 3'($urandom_range(0, 7));
  endtask

  // Keep the given lanes valid for n cycles, refreshing payload after each handshake.
  task automatic stream(input int n, input logic [1:0] lanes);
    logic [1:0] hs;
    @(posedge clk); #1;
    rand_lane(0); rand_lane(1);
    req_valid = lanes;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hs       = req_valid & req_ready;
      last_rdy = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (hs[i]) rand_lane(i);
    end
    req_valid = 2'b00;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  // One request on one lane; lat counts negedges after the handshake edge until res_valid.
  task automatic send1(input string tag, input int lane, input logic [24:0] m, input logic g,
                       input logic s, input logic sg, input logic [2:0] md,
                       output logic [27:0] got, output int lat);
    logic ok;
    @(posedge clk); #1;
    req_mant[lane] = m; req_guard[lane] = g; req_sticky[lane] = s;
    req_sign[lane] = sg; req_round[lane] = md; req_valid[lane] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[lane]) begin ok = 1'b1; break; end
    end
    chk({tag, "_hs"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    ok  = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; lat = k; break; end
    end
    chk({tag, "_res"}, 32'(ok), 32'd1);
    got = {res_src, res_exp_inc, res_inexact, res_mant};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [27:0] got;
  int          lat, h0, c0;
  logic [24:0] t_mant[8] = '{25'h0800000, 25'h0800000, 25'h0800000, 25'h0800000,
                             25'h0800000, 25'h0800000, 25'h0800000, 25'h0800001};
  logic [2:0]  t_mode[8] = '{IEEE_ZERO, IEEE_NEAR, NEAR_UP, AWAY_ZERO,
                             IEEE_PINF, IEEE_NINF, IEEE_NINF, 3'd7};
  logic        t_sign[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic        t_grd[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
  logic        t_stk[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
  logic [24:0] t_exp[8]  = '{25'h0800000, 25'h0800000, 25'h0800000, 25'h0800001,
                             25'h0800001, 25'h0800000, 25'h0800001, 25'h0800002};

  initial begin
    rst = 1'b1; req_valid = '0; req_mant = '0; req_guard = '0; req_sticky = '0;
    req_sign = '0; req_round = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(inexact_cnt), 32'd0);
    chk("rst_res", 32'({res_src, res_exp_inc, res_inexact, res_mant}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    send1("t1", 0, 25'h0800001, 1'b1, 1'b0, 1'b0, IEEE_NEAR, got, lat);
    chk("t1_latency", 32'(lat), 32'd1);
    chk("t1_result", 32'(got), 32'({1'b0, 1'b0, 1'b1, 25'h0800002}));
    wait_drain("t1");

    c0 = int'(inexact_cnt);
    send1("t2", 1, 25'h0FFFFFF, 1'b1, 1'b1, 1'b0, IEEE_NEAR, got, lat);
    chk("t2_result", 32'(got), 32'({1'b1, 1'b1, 1'b1, 25'h0800000}));
    @(negedge clk);
    chk("t2_cnt_inc", 32'(inexact_cnt), 32'(c0 + 1));
    wait_drain("t2");

    gnt_q.delete(); dlv_cyc.delete();
    stream(6, 2'b11);
    wait_drain("t3");
    chk("t3_ngrants", 32'(gnt_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_q.size(); i++)
      chk($sformatf("t3_grant%0d", i), 32'(gnt_q[i]), 32'(i % 2));
    chk("t3_nres", 32'(dlv_cyc.size()), 32'd6);
    if (dlv_cyc.size() == 6) chk("t3_back_to_back", 32'(dlv_cyc[5] - dlv_cyc[0]), 32'd5);

    for (int i = 0; i < 8; i++) begin
      send1($sformatf("mode%0d", i), 0, t_mant[i], t_grd[i], t_stk[i], t_sign[i], t_mode[i],
            got, lat);
      chk($sformatf("mode%0d_mant", i), 32'(got[24:0]), 32'(t_exp[i]));
    end
    wait_drain("modes");

    @(posedge clk); #1 res_ready = 1'b0;
    h0 = hs_cnt;
    stream(5, 2'b11);
    chk("bp_handshakes", 32'(hs_cnt - h0), 32'd2);
    chk("bp_ready_low", 32'(last_rdy), 32'd0);
    res_ready = 1'b1;
    stream(4, 2'b11);
    wait_drain("bp");

    @(posedge clk); #1 res_ready = 1'b0;
    stream(3, 2'b01);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    chk("pre_rst_cnt_nz", 32'(inexact_cnt != 0), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    chk("post_rst_cnt", 32'(inexact_cnt), 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    rand_lane(0); rand_lane(1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_first_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
